serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 166 ++++++++++++++++
 tb/tb_serial_addsub.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one bit per clock.
// Ports: clock, reset (sync, high), start, mode (0 add, 1 sub), a_in, b_in
//   in; busy, done, so, result, carry_out, borrow, overflow, magnitude out.
// Define SERIAL_ADDSUB_MAGNITUDE_EN to build the |A-B| magnitude register;
// without it the magnitude port is tied to 0.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             so,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             borrow,
   output logic             overflow,
   output logic [WIDTH-1:0] magnitude
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_mode;
   logic             r_carry;
   logic             r_co;
   logic             r_bw;
   logic             r_ov;

   logic w_accept;
   logic w_shift;
   logic w_bb;
   logic w_sum;
   logic w_cnext;
   logic w_last;

   // Subtract is A + ~B + 1: B is inverted bit by bit and the
   // carry register is seeded with mode.
   assign w_bb    = r_b[0] ^ r_mode;
   assign w_sum   = r_a[0] ^ w_bb ^ r_carry;
   assign w_cnext = (r_a[0] & w_bb) | (r_a[0] & r_carry) | (w_bb & r_carry);
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_shift  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      so       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            busy    = 1'b1;
            so      = w_sum;
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_mode  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_co    <= 1'b0;
         r_bw    <= 1'b0;
         r_ov    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a_in;
         r_b     <= b_in;
         r_mode  <= mode;
         r_carry <= mode;
         r_cnt   <= '0;
         r_res   <= '0;
         r_co    <= 1'b0;
         r_bw    <= 1'b0;
         r_ov    <= 1'b0;
      end else if (w_shift) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_cnext;
         r_cnt   <= r_cnt + 1'b1;
         r_res   <= {w_sum, r_res[WIDTH-1:1]};
         if (w_last) begin
            // r_carry here is the carry into the MSB
            r_co <= w_cnext;
            r_bw <= r_mode & ~w_cnext;
            r_ov <= r_carry ^ w_cnext;
         end
      end
   end

   assign result    = r_res;
   assign carry_out = r_co;
   assign borrow    = r_bw;
   assign overflow  = r_ov;

`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] w_fin;

   assign w_fin = {w_sum, r_res[WIDTH-1:1]};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mag <= '0;
      end else if (w_accept) begin
         r_mag <= '0;
      end else if (w_shift && w_last) begin
         if (r_mode & ~w_cnext) begin
            r_mag <= ~w_fin + 1'b1;
         end else begin
            r_mag <= w_fin;
         end
      end
   end

   assign magnitude = r_mag;
`else
   assign magnitude = '0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and random operations on serial_addsub,
// checked against an integer-arithmetic reference model.
module tb_serial_addsub;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         mode  = 1'b0;
   logic [W-1:0] a_in  = '0;
   logic [W-1:0] b_in  = '0;
   logic         busy;
   logic         done;
   logic         so;
   logic [W-1:0] result;
   logic         carry_out;
   logic         borrow;
   logic         overflow;
   logic [W-1:0] magnitude;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] held_res = '0;

   serial_addsub #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .so       (so),
      .result   (result),
      .carry_out(carry_out),
      .borrow   (borrow),
      .overflow (overflow),
      .magnitude(magnitude)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned sum/difference, signed range test.
   function automatic void model(
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  logic         m,
      output logic [W-1:0] r,
      output logic         co,
      output logic         bw,
      output logic         ov,
      output logic [W-1:0] mag
   );
      int unsigned ua = a;
      int unsigned ub = b;
      int unsigned s;
      int sa = $signed(a);
      int sb = $signed(b);
      int ss;
      if (!m) begin
         s  = ua + ub;
         co = (s >= 2 ** W);
         ss = sa + sb;
      end else begin
         s  = ua - ub;
         co = (ua >= ub);
         ss = sa - sb;
      end
      r  = s[W-1:0];
      bw = m && !co;
      ov = (ss > 2 ** (W - 1) - 1) || (ss < -(2 ** (W - 1)));
`ifdef SERIAL_ADDSUB_MAGNITUDE_EN
      mag = bw ? W'(ub - ua) : r;
`else
      mag = '0;
`endif
   endfunction

   task automatic idle_check(input string tag);
      check({tag, ":idle_busy"}, 32'(busy), 0);
      check({tag, ":idle_done"}, 32'(done), 0);
      check({tag, ":idle_so"}, 32'(so), 0);
      check({tag, ":held_res"}, 32'(result), 32'(held_res));
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic m, input string tag,
                     input bit poke_shift, input bit poke_done);
      logic [W-1:0] er;
      logic [W-1:0] emag;
      logic [W-1:0] sov;
      logic         eco;
      logic         ebw;
      logic         eov;
      model(a, b, m, er, eco, ebw, eov, emag);
      @(negedge clock);
      idle_check(tag);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      mode  = m;
      @(negedge clock);
      start = 1'b0;
      a_in  = ~a;
      b_in  = a ^ b;
      mode  = ~m;
      sov   = '0;
      for (int i = 1; i <= W; i++) begin
         if (i > 1) @(negedge clock);
         check({tag, ":busy"}, 32'(busy), 1);
         check({tag, ":no_done"}, 32'(done), 0);
         sov[i-1] = so;
         if (poke_shift && i == 3) begin
            start = 1'b1;
            a_in  = W'($urandom);
            b_in  = W'($urandom);
         end
         if (poke_shift && i == 4) start = 1'b0;
      end
      @(negedge clock);
      check({tag, ":done"}, 32'(done), 1);
      check({tag, ":busy_off"}, 32'(busy), 0);
      check({tag, ":so_off"}, 32'(so), 0);
      check({tag, ":result"}, 32'(result), 32'(er));
      check({tag, ":so_stream"}, 32'(sov), 32'(er));
      check({tag, ":carry_out"}, 32'(carry_out), 32'(eco));
      check({tag, ":borrow"}, 32'(borrow), 32'(ebw));
      check({tag, ":overflow"}, 32'(overflow), 32'(eov));
      check({tag, ":magnitude"}, 32'(magnitude), 32'(emag));
      held_res = er;
      if (poke_done) begin
         start = 1'b1;
         a_in  = W'($urandom);
         b_in  = W'($urandom);
      end
   endtask

   task automatic all_zero(input string tag);
      check({tag, ":busy"}, 32'(busy), 0);
      check({tag, ":done"}, 32'(done), 0);
      check({tag, ":so"}, 32'(so), 0);
      check({tag, ":result"}, 32'(result), 0);
      check({tag, ":carry_out"}, 32'(carry_out), 0);
      check({tag, ":borrow"}, 32'(borrow), 0);
      check({tag, ":overflow"}, 32'(overflow), 0);
      check({tag, ":magnitude"}, 32'(magnitude), 0);
   endtask

   initial begin
      bit saw_done;
      repeat (2) @(negedge clock);
      all_zero("reset");
      reset = 1'b0;

      op(8'hAA, 8'h5B, 1'b1, "sub_aa_5b", 1'b1, 1'b0);
      op(8'h5D, 8'hFD, 1'b1, "sub_5d_fd", 1'b0, 1'b1);
      op(8'h7F, 8'h01, 1'b0, "add_7f_01", 1'b0, 1'b0);
      op(8'hFF, 8'h01, 1'b0, "add_ff_01", 1'b0, 1'b0);
      op(8'h10, 8'h30, 1'b1, "sub_10_30", 1'b0, 1'b0);
      op(8'h80, 8'h01, 1'b1, "sub_80_01", 1'b0, 1'b0);
      op(8'h00, 8'h00, 1'b1, "sub_00_00", 1'b0, 1'b0);

      // abort in the 4th shift cycle
      @(negedge clock);
      idle_check("abort");
      start = 1'b1;
      a_in  = 8'hC3;
      b_in  = 8'h3C;
      mode  = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      all_zero("abort");
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clock);
         saw_done = saw_done | done;
      end
      check("abort:no_done_pulse", 32'(saw_done), 0);
      held_res = '0;

      // reset wins over start
      reset = 1'b1;
      start = 1'b1;
      a_in  = 8'h12;
      b_in  = 8'h34;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      check("prio:busy", 32'(busy), 0);
      @(negedge clock);
      check("prio:busy_later", 32'(busy), 0);

      for (int n = 0; n < 30; n++) begin
         op(W'($urandom), W'($urandom), 1'($urandom), "rnd",
            1'($urandom), 1'($urandom));
      end
      @(negedge clock);
      idle_check("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
